mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter for the single unified instruction/data memory of the multicycle core. The core's fetch and load/store path is the CPU port. The debug/program-loader path is the DBG port. The block grants one requester at a time, drives the memory port for exactly one access cycle, waits MEM_LAT cycles and returns registered read data with a response pulse. The core's control FSM stalls in its memory states until cpu_rvalid.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req  in  1  CPU access request; held until cpu_gnt
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle grant; request fields are consumed
cpu_rvalid  out  1  one-cycle response; read data valid, or write done
cpu_rdata  out  DW  read data, valid with cpu_rvalid
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  same semantics as the CPU inputs
dbg_gnt, dbg_rvalid  out  1  same semantics as the CPU outputs
dbg_rdata  out  DW  same semantics as cpu_rdata
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - state=IDLE, last_owner=DBG, wait counter=0.
  - All outputs are 0: every gnt, rvalid, mem_en, mem_we, busy, and all data/address outputs.
  - Reset mid-transaction drops the access silently. No rvalid is issued.
- States:
  - IDLE: pick a winner from the req inputs. With no request, stay in IDLE.
  - ACCESS: lasts 1 cycle. mem_en=1; mem_we/addr/wdata come from fields latched at the pick edge. The winner's gnt=1.
  - WAIT: counts 1..MEM_LAT-1. Skipped when MEM_LAT=1.
  - RESP: winner's rvalid=1 and rdata=captured value for 1 cycle. Arbitration is re-evaluated here.
- Data capture: mem_rdata is sampled at the end of cycle ACCESS+MEM_LAT-1, i.e. the final WAIT cycle, or the ACCESS cycle when MEM_LAT=1. rdata outputs hold that value until the next capture.
- Writes complete the same sequence. rvalid is the write acknowledge; rdata is don't-care but holds its previous value.
- Latency: req first seen high in IDLE at edge k gives gnt in cycle k+1 and rvalid in cycle k+1+MEM_LAT. mem_en asserts exactly once per grant.
- Back-to-back accesses: in RESP, a pending req goes directly to ACCESS, so there is no idle bubble. Throughput is 1 access per MEM_LAT+1 cycles.
- Requester rules:
  - req is level, held until gnt, and may be dropped in the cycle after gnt.
  - req still high in RESP counts as a new request.
  - Dropping req before gnt withdraws it only if the arbiter has not yet picked it.
- Arbitration is round-robin:
  - Only one requesting: that one wins.
  - Both requesting: the one that is not last_owner wins.
  - last_owner updates at each pick.
- Requests do not affect outputs while in ACCESS or WAIT. The latched fields are immune to input changes after the pick.
- Non-owner gnt/rvalid stay 0. The two gnts are never high together; same for the two rvalids.

Optional Feature:
MEM_ARB_CPU_PRIO_EN
- Defined: fixed priority. cpu_req always wins when both requesters are active. last_owner is still tracked but ignored.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3
  - owner constants: OWN_CPU=1'b0, OWN_DBG=1'b1
  - MEM_LAT_MAX=15
- Sub-module mem_arb_pick: combinational 2-way pick from req vector, last_owner and the priority macro. Outputs winner and valid.

Test Plan:
- MEM_LAT=1, cpu read only: cpu_req high at cycle 2 with addr 0x40; memory returns 0xDEADBEEF.
  -> cpu_gnt at cycle 3, mem_en=1 with mem_addr=0x40 at cycle 3, cpu_rvalid and cpu_rdata=0xDEADBEEF at cycle 4, busy low at cycle 5.
- MEM_LAT=3, dbg write: addr 0x10, data 0x1234.
  -> mem_en and mem_we high for exactly 1 cycle; dbg_rvalid 3 cycles after dbg_gnt; memory word 0x10 reads back as 0x1234.
- Both requesters held high continuously for 6 grants, round-robin build.
  -> grants alternate CPU, DBG, CPU, ... with no idle cycle between RESP and ACCESS. With MEM_ARB_CPU_PRIO_EN defined: all 6 grants go to CPU.
- rst asserted during WAIT of a CPU read.
  -> next cycle all outputs 0 and state IDLE; no cpu_rvalid ever issued; a subsequent tied request goes to CPU (last_owner=DBG).
- cpu_addr and cpu_wdata changed in the cycle after cpu_gnt.
  -> mem_addr/mem_wdata during ACCESS equal the values latched at the pick; response unaffected.
- Debug loads words 0..7 (0x100+i), then CPU reads addresses 0..7.
  -> CPU read data equals 0x100..0x107 in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Consumed by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    function automatic logic other_owner(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way pick between CPU (req[0]) and DBG (req[1]).
// Round-robin by default; fixed CPU priority when MEM_ARB_CPU_PRIO_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        if (req[OWN_CPU] && req[OWN_DBG]) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            winner = OWN_CPU;
`else
            winner = other_owner(last_owner);
`endif
        end else if (req[OWN_DBG]) begin
            winner = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU, DBG) for the core's unified memory: one access
// strobe per grant, MEM_LAT wait, registered response. Option: MEM_ARB_CPU_PRIO_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               owner_q;
    logic               last_owner_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW-1:0]      rdata_q;

    logic               load;
    logic               capture;
    logic               pick_winner;
    logic               pick_valid;

    mem_arb_pick u_pick (
        .req        ({dbg_req, cpu_req}),
        .last_owner (last_owner_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
        end
    end

    // Picks happen only in IDLE and RESP; RESP->ACCESS gives bubble-free back-to-back.
    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (MEM_LAT == 1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at the pick so later input changes cannot leak into the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (load) begin
                owner_q      <= pick_winner;
                last_owner_q <= pick_winner;
                if (pick_winner == OWN_CPU) begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end else begin
                    we_q    <= dbg_we;
                    addr_q  <= dbg_addr;
                    wdata_q <= dbg_wdata;
                end
            end
            if (capture && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en     = (state == ACCESS);
    assign mem_we     = mem_en && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign cpu_gnt    = mem_en && (owner_q == OWN_CPU);
    assign dbg_gnt    = mem_en && (owner_q == OWN_DBG);
    assign cpu_rvalid = (state == RESP) && (owner_q == OWN_CPU);
    assign dbg_rvalid = (state == RESP) && (owner_q == OWN_DBG);
    assign cpu_rdata  = rdata_q;
    assign dbg_rdata  = rdata_q;

    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// selected by sel; each has its own memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    int            lat = 1;

    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;

    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    logic          cpu_gnt1, cpu_rvalid1, dbg_gnt1, dbg_rvalid1, mem_en1, mem_we1, busy1;
    logic [DW-1:0] cpu_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;
    logic          cpu_gnt3, cpu_rvalid3, dbg_gnt3, dbg_rvalid3, mem_en3, mem_we3, busy3;
    logic [DW-1:0] cpu_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0] mem_addr3;

    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int tests = 0;
    int fails = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .dbg_req(dbg_req & ~sel), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .dbg_req(dbg_req & sel), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    assign cpu_gnt    = sel ? cpu_gnt3    : cpu_gnt1;
    assign cpu_rvalid = sel ? cpu_rvalid3 : cpu_rvalid1;
    assign cpu_rdata  = sel ? cpu_rdata3  : cpu_rdata1;
    assign dbg_gnt    = sel ? dbg_gnt3    : dbg_gnt1;
    assign dbg_rvalid = sel ? dbg_rvalid3 : dbg_rvalid1;
    assign dbg_rdata  = sel ? dbg_rdata3  : dbg_rdata1;
    assign mem_en     = sel ? mem_en3     : mem_en1;
    assign mem_we     = sel ? mem_we3     : mem_we1;
    assign mem_addr   = sel ? mem_addr3   : mem_addr1;
    assign mem_wdata  = sel ? mem_wdata3  : mem_wdata1;
    assign busy       = sel ? busy3       : busy1;

    // Memory models: LAT=1 reads combinationally in the strobe cycle, LAT=3 through two stages.
    logic [DW-1:0] mem1 [0:255];
    logic [DW-1:0] mem3 [0:255];
    logic [DW-1:0] d1, d2;

    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_addr] <= pl_data;
            mem3[pl_addr] <= pl_data;
        end
        if (mem_en1 && mem_we1) mem1[mem_addr1[7:0]] <= mem_wdata1;
        if (mem_en3 && mem_we3) mem3[mem_addr3[7:0]] <= mem_wdata3;
        d1 <= (mem_en3 && !mem_we3) ? mem3[mem_addr3[7:0]] : 32'hBAD0_BAD0;
        d2 <= d1;
    end

    assign mem_rdata1 = (mem_en1 && !mem_we1) ? mem1[mem_addr1[7:0]] : 32'hBAD1_BAD1;
    assign mem_rdata3 = d2;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_gnt"},    cpu_gnt,    0);
        check({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        check({tag, "_cpu_rdata"},  cpu_rdata,  0);
        check({tag, "_dbg_gnt"},    dbg_gnt,    0);
        check({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
        check({tag, "_dbg_rdata"},  dbg_rdata,  0);
        check({tag, "_mem_en"},     mem_en,     0);
        check({tag, "_mem_we"},     mem_we,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_mem_wdata"},  mem_wdata,  0);
        check({tag, "_busy"},       busy,       0);
    endtask

    // One full access; inputs are scrambled right after the grant to prove they were latched.
    task automatic do_access(input logic who, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output logic [DW-1:0] rdata);
        int   n;
        logic got;
        if (who == OWN_CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = (who == OWN_CPU) ? cpu_gnt : dbg_gnt;
        end
        check("acc_gnt_seen", got, 1);
        if (who == OWN_CPU) begin
            cpu_we = ~we; cpu_addr = addr ^ 32'hFF; cpu_wdata = ~wdata;
        end else begin
            dbg_we = ~we; dbg_addr = addr ^ 32'hFF; dbg_wdata = ~wdata;
        end
        #1;
        check("acc_other_gnt", (who == OWN_CPU) ? dbg_gnt : cpu_gnt, 0);
        check("acc_mem_en",    mem_en,    1);
        check("acc_mem_we",    mem_we,    we);
        check("acc_mem_addr",  mem_addr,  addr);
        check("acc_mem_wdata", mem_wdata, wdata);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        rdata = '0;
        for (int i = 1; i <= lat; i++) begin
            step();
            check("acc_rvalid", (who == OWN_CPU) ? cpu_rvalid : dbg_rvalid, (i == lat));
            check("acc_other_rvalid", (who == OWN_CPU) ? dbg_rvalid : cpu_rvalid, 0);
            check("acc_mem_en_once", mem_en, 0);
            if (i == lat) rdata = (who == OWN_CPU) ? cpu_rdata : dbg_rdata;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int   grants, cyc, last_g, n;
        logic got;

        // Preload both memories while reset is held.
        rst   = 1'b1;
        pl_en = 1'b1;
        for (int a = 0; a < 256; a++) begin
            pl_addr = 8'(a);
            pl_data = (a == 8'h40) ? 32'hDEAD_BEEF : {24'hC0FFEE, 8'(a)};
            step();
        end
        pl_en = 1'b0;

        // Reset state and the exact-cycle CPU read at MEM_LAT=1.
        sel = 1'b0; lat = 1;
        step();
        check_all_zero("reset1");
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
        step();
        check("t1_cpu_gnt",  cpu_gnt,  1);
        check("t1_dbg_gnt",  dbg_gnt,  0);
        check("t1_mem_en",   mem_en,   1);
        check("t1_mem_we",   mem_we,   0);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_busy",     busy,     1);
        cpu_req = 1'b0;
        step();
        check("t1_rvalid", cpu_rvalid, 1);
        check("t1_rdata",  cpu_rdata,  32'hDEAD_BEEF);
        check("t1_mem_en_off", mem_en, 0);
        step();
        check("t1_busy_off",   busy,       0);
        check("t1_rvalid_off", cpu_rvalid, 0);

        // DBG write at MEM_LAT=3; rdata holds across a write.
        sel = 1'b1; lat = 3;
        apply_reset();
        do_access(OWN_DBG, 1'b0, 32'h10, 32'h0, rd);
        check("t2_pre_read", rd, 32'hC0FF_EE10);
        do_access(OWN_DBG, 1'b1, 32'h10, 32'h1234, rd);
        check("t2_wr_rdata_hold", rd, 32'hC0FF_EE10);
        check("t2_mem_word", mem3[8'h10], 32'h1234);
        do_access(OWN_DBG, 1'b0, 32'h10, 32'h0, rd);
        check("t2_readback", rd, 32'h1234);

        // Latched fields at MEM_LAT=3: scrambled address must stay untouched.
        do_access(OWN_CPU, 1'b1, 32'h20, 32'hA5A5_A5A5, rd);
        check("t5_mem_written", mem3[8'h20], 32'hA5A5_A5A5);
        check("t5_scrambled_untouched", mem3[8'hDF], 32'hC0FF_EEDF);
        drain();

        // Both requesters held for 6 grants at each latency.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            lat = (s == 0) ? 1 : 3;
            apply_reset();
            exp_q = {};
            for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
                exp_q.push_back(OWN_CPU);
`else
                exp_q.push_back((g % 2 == 0) ? OWN_CPU : OWN_DBG);
`endif
            end
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h2;
            grants = 0; cyc = 0; last_g = 0;
            while (grants < 6 && cyc < 100) begin
                step();
                cyc++;
                check("rr_one_gnt",    cpu_gnt & dbg_gnt,       0);
                check("rr_one_rvalid", cpu_rvalid & dbg_rvalid, 0);
                if (cpu_gnt || dbg_gnt) begin
                    check("rr_owner", dbg_gnt, exp_q.pop_front());
                    if (grants > 0) check("rr_spacing", cyc - last_g, lat + 1);
                    last_g = cyc;
                    grants++;
                end
            end
            check("rr_count", grants, 6);
            cpu_req = 1'b0;
            dbg_req = 1'b0;
            drain();
        end

        // Reset during WAIT of a CPU read at MEM_LAT=3.
        sel = 1'b1; lat = 3;
        apply_reset();
        do_access(OWN_CPU, 1'b0, 32'h30, 32'h0, rd);
        check("t4_first_read", rd, 32'hC0FF_EE30);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h34;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = cpu_gnt;
        end
        check("t4_gnt_seen", got, 1);
        cpu_req = 1'b0;
        step();
        check("t4_in_wait", u_dut3.state, WAIT);
        rst = 1'b1;
        step();
        check_all_zero("t4_rst");
        check("t4_state", u_dut3.state, IDLE);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t4_no_rvalid", cpu_rvalid, 0);
        end
        cpu_req = 1'b1; dbg_req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = cpu_gnt | dbg_gnt;
        end
        check("t4_tie_cpu", cpu_gnt, 1);
        check("t4_tie_dbg", dbg_gnt, 0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        drain();

        // DBG loads words 0..7, CPU reads them back at MEM_LAT=1.
        sel = 1'b0; lat = 1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_access(OWN_DBG, 1'b1, AW'(i), DW'(32'h100 + i), rd);
        end
        for (int i = 0; i < 8; i++) begin
            do_access(OWN_CPU, 1'b0, AW'(i), 32'h0, rd);
            check("t6_readback", rd, DW'(32'h100 + i));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
